// File: rtl/mult_ctrl_pkg.sv
// Shared types and default sizing for the Booth multiplier issue controller.
package mult_ctrl_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_RUN_CYCLES = 33;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_LATCH  = 3'd4,
    S_SAMPLE = 3'd5
  } state_t;

endpackage

// File: rtl/op_fifo.sv
// Small operand-pair queue: count-based full/empty, head visible combinationally.
module op_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/booth_issue_ctrl.sv
// Issue controller for an iterative Booth multiplier: queues operand pairs,
// sequences load/start/run/latch on the core and hands back one product at a time.
module booth_issue_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int RUN_CYCLES = DEF_RUN_CYCLES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_en,
  output logic               mul_start,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               busy
);

  localparam int                CNT_W    = $clog2(RUN_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RUN_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_count;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;
  logic                 r_mul_en;
  logic                 r_mul_start;
  logic                 r_out_valid;
  logic [2*WIDTH-1:0]   r_out_prod;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [2*WIDTH-1:0]   w_head;
  logic                 w_out_free;

  op_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_op_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (w_push),
    .push_data ({in_a, in_b}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  // The output slot counts as free when the pending result is being taken on
  // this same edge, so back-to-back products issue every RUN_CYCLES+5 cycles.
  assign w_out_free = !r_out_valid || out_ready;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && w_out_free) begin
          w_state_next = S_LOAD;
          w_pop        = 1'b1;
        end
      end
      S_LOAD:   w_state_next = S_START;
      S_START:  w_state_next = S_RUN;
      S_RUN:    if (r_count == CNT_LAST) w_state_next = S_LATCH;
      S_LATCH:  w_state_next = S_SAMPLE;
      S_SAMPLE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_en    <= 1'b0;
      r_mul_start <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_prod  <= '0;
    end else begin
      r_state <= w_state_next;
      // Core strobes are decoded from the next state so they line up with it.
      r_mul_en    <= (w_state_next == S_LOAD) || (w_state_next == S_LATCH);
      r_mul_start <= (w_state_next == S_START);
      if (r_state == S_RUN) r_count <= r_count + CNT_W'(1);
      else                  r_count <= '0;
      if (w_pop) begin
        r_mul_a <= w_head[2*WIDTH-1:WIDTH];
        r_mul_b <= w_head[WIDTH-1:0];
      end
      if (r_state == S_SAMPLE) begin
        r_out_prod  <= mul_result;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_en    = r_mul_en;
  assign mul_start = r_mul_start;
  assign out_valid = r_out_valid;
  assign out_prod  = r_out_prod;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Directed bench for booth_issue_ctrl with a simple start/latch core stand-in.
module tb_booth_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_prod;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_en;
  logic        mul_start;
  logic [63:0] mul_result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Core stand-in: multiplies on start, exposes the result only after an enable.
  logic [63:0] r_core_acc = '0;
  logic [63:0] r_core_res = '0;
  always @(posedge clk) begin
    if (mul_start) r_core_acc <= $signed(mul_a) * $signed(mul_b);
    if (mul_en)    r_core_res <= r_core_acc;
  end
  assign mul_result = r_core_res;

  always #5 clk = ~clk;

  booth_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_en     (mul_en),
    .mul_start  (mul_start),
    .mul_result (mul_result),
    .busy       (busy)
  );

  logic [31:0] bp_a [4] = '{32'd2, 32'd4, -32'sd6, 32'd11};
  logic [31:0] bp_b [4] = '{32'd3, 32'd5, 32'd9, 32'd13};
  logic [31:0] st_a [6] = '{32'd1, -32'sd2, 32'd100, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd12345};
  logic [31:0] st_b [6] = '{32'd1, 32'd3, -32'sd100, 32'd2, 32'hFFFFFFFF, 32'd678};
  logic [63:0] st_p [6] = '{64'd1, 64'hFFFFFFFFFFFFFFFA, 64'hFFFFFFFFFFFFD8F0,
                            64'h00000000FFFFFFFE, 64'd1, 64'h00000000007FB6F6};

  task automatic push_op(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_prod !== 64'd0) begin errors++; $display("FAIL reset_out_prod got=%h exp=0", out_prod); end
    checks++; if ({mul_en, mul_start} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {mul_en, mul_start}); end
    checks++; if ({mul_a, mul_b} !== 64'd0) begin errors++; $display("FAIL reset_mul_ops got=%h exp=0", {mul_a, mul_b}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_single();
    int lat = -1, en_cnt = 0, st_cnt = 0, both = 0, st_at = -1, en_first = -1, en_last = -1;
    logic ov_after = 1'b1;
    out_ready = 1'b1;
    push_op(32'd6, 32'd7);
    for (int k = 1; k <= 39; k++) begin
      @(posedge clk); #1;
      if (mul_en) begin
        en_cnt++;
        if (en_first < 0) en_first = k;
        en_last = k;
      end
      if (mul_start) begin st_cnt++; st_at = k; end
      if (mul_en && mul_start) both++;
      if (out_valid && lat < 0) lat = k;
      if (k == 39) ov_after = out_valid;
      if (k == 2) begin
        checks++; if ({mul_a, mul_b} !== {32'd6, 32'd7}) begin errors++; $display("FAIL single_mul_ops got=%h exp=%h", {mul_a, mul_b}, {32'd6, 32'd7}); end
      end
      if (k == 38) begin
        checks++; if (out_prod !== 64'd42) begin errors++; $display("FAIL single_prod got=%0d exp=42", out_prod); end
      end
    end
    checks++; if (lat !== 38) begin errors++; $display("FAIL single_latency got=%0d exp=38", lat); end
    checks++; if (en_first !== 1) begin errors++; $display("FAIL single_load_en got=%0d exp=1", en_first); end
    checks++; if (st_at !== 2 || st_cnt !== 1) begin errors++; $display("FAIL single_start got=%0d/%0d exp=2/1", st_at, st_cnt); end
    checks++; if (en_last !== 36 || en_cnt !== 2) begin errors++; $display("FAIL single_latch_en got=%0d/%0d exp=36/2", en_last, en_cnt); end
    checks++; if (both !== 0) begin errors++; $display("FAIL single_en_start_overlap got=%0d exp=0", both); end
    checks++; if (ov_after !== 1'b0) begin errors++; $display("FAIL single_out_valid_clear got=%b exp=0", ov_after); end
    $display("test_single: 6*7 latency=%0d", lat);
  endtask

  task automatic test_signed();
    int c;
    out_ready = 1'b1;
    push_op(-32'sd3, 32'd7);
    wait_out_valid(100, c);
    checks++; if (c !== 38 || out_prod !== 64'hFFFFFFFFFFFFFFEB) begin errors++; $display("FAIL signed_neg got=%h lat=%0d exp=ffffffffffffffeb lat=38", out_prod, c); end
    @(posedge clk); #1;
    push_op(32'h80000000, 32'h80000000);
    wait_out_valid(100, c);
    checks++; if (c !== 38 || out_prod !== 64'h4000000000000000) begin errors++; $display("FAIL signed_min got=%h lat=%0d exp=4000000000000000 lat=38", out_prod, c); end
    @(posedge clk); #1;
    $display("test_signed: done");
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1;
    logic [63:0] p1 = '0, p2 = '0;
    out_ready = 1'b1;
    push_op(32'd10, 32'd20);
    push_op(-32'sd4, 32'd8);
    for (int t = 2; t <= 100 && t2 < 0; t++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (t1 < 0) begin t1 = t; p1 = out_prod; end
        else begin t2 = t; p2 = out_prod; end
      end
    end
    checks++; if (t1 !== 38) begin errors++; $display("FAIL b2b_first_lat got=%0d exp=38", t1); end
    checks++; if (t2 - t1 !== 38) begin errors++; $display("FAIL b2b_interval got=%0d exp=38", t2 - t1); end
    checks++; if (p1 !== 64'd200) begin errors++; $display("FAIL b2b_prod1 got=%h exp=c8", p1); end
    checks++; if (p2 !== 64'hFFFFFFFFFFFFFFE0) begin errors++; $display("FAIL b2b_prod2 got=%h exp=ffffffffffffffe0", p2); end
    @(posedge clk); #1;
    $display("test_back_to_back: interval=%0d", t2 - t1);
  endtask

  task automatic test_backpressure();
    logic acc [4];
    int c, busy_cnt = 0, unstable = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a = bp_a[i];
      in_b = bp_b[i];
      acc[i] = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if ({acc[0], acc[1], acc[2], acc[3]} !== 4'b1110) begin errors++; $display("FAIL bp_accept got=%b exp=1110", {acc[0], acc[1], acc[2], acc[3]}); end
    wait_out_valid(100, c);
    checks++; if (c < 0 || out_prod !== 64'd6) begin errors++; $display("FAIL bp_res1 got=%h exp=6", out_prod); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (out_prod !== 64'd6 || !out_valid) unstable++;
    end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL bp_op2_held got=%0d busy cycles exp=0", busy_cnt); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", unstable); end
    take_result();
    wait_out_valid(100, c);
    checks++; if (c !== 37 || out_prod !== 64'd20) begin errors++; $display("FAIL bp_res2 got=%h lat=%0d exp=14 lat=37", out_prod, c); end
    take_result();
    wait_out_valid(100, c);
    checks++; if (c < 0 || out_prod !== 64'hFFFFFFFFFFFFFFCA) begin errors++; $display("FAIL bp_res3 got=%h exp=ffffffffffffffca", out_prod); end
    take_result();
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy || out_valid) busy_cnt++;
    end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL bp_drained got=%0d active cycles exp=0", busy_cnt); end
    $display("test_backpressure: done");
  endtask

  task automatic test_fifo_stress();
    logic [63:0] sb [$];
    logic [63:0] exp_p;
    int sent = 0, got = 0;
    for (int cyc = 0; cyc < 1500 && got < 6; cyc++) begin
      out_ready = ((cyc / 48) % 2) == 1;
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_a = st_a[sent];
        in_b = st_b[sent];
      end
      if (out_valid && out_ready) begin
        exp_p = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
        checks++; if (out_prod !== exp_p) begin errors++; $display("FAIL stress_prod%0d got=%h exp=%h", got, out_prod, exp_p); end
        $display("stress: result %0d = %h", got, out_prod);
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(st_p[sent]);
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (got !== 6) begin errors++; $display("FAIL stress_count got=%0d exp=6", got); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL stress_leftover got=%0d exp=0", sb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int c, active = 0;
    out_ready = 1'b1;
    push_op(32'd9, 32'd9);
    push_op(32'd3, 32'd3);
    repeat (12) @(posedge clk);
    #4;
    checks++; if (busy !== 1'b1 || mul_en !== 1'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL midrun_pre got=%b%b%b exp=100", busy, mul_en, mul_start); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_busy got=%b exp=0", busy); end
    checks++; if ({mul_en, mul_start, out_valid} !== 3'b000) begin errors++; $display("FAIL midrun_flags got=%b exp=000", {mul_en, mul_start, out_valid}); end
    checks++; if ({mul_a, mul_b} !== 64'd0) begin errors++; $display("FAIL midrun_mul_ops got=%h exp=0", {mul_a, mul_b}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrun_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (busy || out_valid) active++;
    end
    checks++; if (active !== 0) begin errors++; $display("FAIL midrun_discard got=%0d active cycles exp=0", active); end
    push_op(32'd5, -32'sd5);
    wait_out_valid(100, c);
    checks++; if (c !== 38) begin errors++; $display("FAIL midrun_latency got=%0d exp=38", c); end
    checks++; if (out_prod !== 64'hFFFFFFFFFFFFFFE7) begin errors++; $display("FAIL midrun_prod got=%h exp=ffffffffffffffe7", out_prod); end
    @(posedge clk); #1;
    $display("test_reset_mid_run: done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_fifo_stress();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_issue_ctrl.md
BOOTH_ISSUE_CTRL -- requirements
Module: booth_issue_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter RUN_CYCLES, default 33, multiplier iteration cycles between start and result capture.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, number of operand-pair queue entries.
REQ-004 SHALL have port clk  in  1  the single clock; all flops rise-edge triggered.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports in_valid in 1, in_ready out 1  operand handshake.
REQ-007 SHALL have ports in_a in WIDTH, in_b in WIDTH  signed multiplier and multiplicand.
REQ-008 SHALL have ports out_valid out 1, out_ready in 1  result handshake.
REQ-009 SHALL have port out_prod  out  2*WIDTH  signed product.
REQ-010 SHALL have ports mul_a out WIDTH, mul_b out WIDTH  operands driven to the Booth core.
REQ-011 SHALL have ports mul_en out 1, mul_start out 1  Booth core register enable and start.
REQ-012 SHALL have port mul_result  in  2*WIDTH  Booth core registered result.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL push {in_a,in_b} into the FIFO on a cycle where in_valid and in_ready are both high; in_ready = FIFO not full.
REQ-015 SHALL accept a push and a pop in the same cycle without loss; no push when full.
REQ-016 SHALL implement states IDLE, LOAD, START, RUN, LATCH, SAMPLE.
REQ-017 IDLE->LOAD when FIFO non-empty and out_valid=0; pops head into registered mul_a/mul_b on that edge.
REQ-018 LOAD: mul_en=1, mul_start=0, one cycle, then START.
REQ-019 START: mul_start=1, mul_en=0, one cycle, then RUN with counter cleared.
REQ-020 RUN: mul_en=0, mul_start=0; counter increments each cycle; leaves for LATCH after exactly RUN_CYCLES cycles.
REQ-021 LATCH: mul_en=1 for one cycle, then SAMPLE.
REQ-022 SAMPLE: on exit edge loads mul_result into out_prod, sets out_valid=1, returns to IDLE.
REQ-023 mul_en and mul_start SHALL be registered outputs, never both high in the same cycle.
REQ-024 out_valid SHALL hold and out_prod SHALL remain stable until out_valid&out_ready; out_valid then clears on that edge.
REQ-025 Latency from acceptance edge (empty FIFO, IDLE, out_valid=0) to out_valid high SHALL be RUN_CYCLES+5 cycles (38 at default).
REQ-026 A new operation SHALL not leave IDLE while out_valid=1; queued operands wait in FIFO.
REQ-027 Throughput SHALL be one product per RUN_CYCLES+5 cycles when out_ready is held high.
REQ-028 in_valid/out_ready changes in RUN SHALL not disturb the counter or mul_* outputs.

Reset
REQ-029 reset SHALL asynchronously force state IDLE, counter 0, FIFO empty, out_valid=0, out_prod=0, mul_a=0, mul_b=0, mul_en=0, mul_start=0, busy=0; in_ready=1 while reset is high.
REQ-030 reset mid-operation SHALL discard the operation in flight and all queued operands; the first operation after release SHALL produce a correct product.

Structure
REQ-031 Shared package mult_ctrl_pkg SHALL hold the state enumeration and default WIDTH/RUN_CYCLES constants.
REQ-032 The operand queue SHALL be a separate sub-module op_fifo (parameterized width/depth, async reset, count-based full/empty).

Verification
REQ-033 Reset: assert reset mid-cycle -> all outputs 0 immediately, in_ready=1.
REQ-034 Single op 6*7, out_ready=1 -> mul_en pulse, mul_start pulse, mul_en pulse at LATCH, out_prod=42 with out_valid high 38 cycles after acceptance.
REQ-035 Signed: -3*7 -> 0xFFFFFFFFFFFFFFEB; 0x80000000*0x80000000 -> 0x4000000000000000.
REQ-036 Backpressure: out_ready=0, push 4 ops -> first three accepted, fourth sees in_ready=0; op2 not started until result1 taken; all results in order.
REQ-037 Reset asserted at RUN count 10 -> IDLE, FIFO empty, out_valid=0; next op 5*-5 -> 0xFFFFFFFFFFFFFFE7.
REQ-038 Full-FIFO push/pop same cycle at LOAD entry -> no operand lost or duplicated (scoreboard against reference model).
